axi_lite_mem_slv: RTL and testbench

- AXI4-Lite responder (slave endpoint) that terminates transactions issued by the core/interconnect master side.
- Backed by an internal word-addressed SRAM array.
- Read and write channels each have a small FSM with a programmable access-latency counter, so the bench and interconnect see realistic multi-cycle memory timing.
- Read and write paths are fully independent and may be in flight simultaneously.

---
 rtl/axi_lite_mem_slv.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_lite_mem_slv.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_slv.sv
// AXI4-Lite memory responder backed by a word-addressed array.
// Independent read and write FSMs, each with a programmable access-latency counter.
module axi_lite_mem_slv #(
  parameter int unsigned       ADDR_W = 32,
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
  parameter int unsigned       R_LAT  = 2,
  parameter int unsigned       W_LAT  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ar_valid,
  output logic                ar_ready,
  input  logic [ADDR_W-1:0]   ar_addr,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [DATA_W-1:0]   r_data,
  output logic [1:0]          r_resp,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  output logic                b_valid,
  input  logic                b_ready,
  output logic [1:0]          b_resp
);

  localparam int unsigned     STRB_W = DATA_W / 8;
  localparam int unsigned     OFF_W  = $clog2(STRB_W);
  localparam int unsigned     IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0] SPAN   = (ADDR_W+1)'(DEPTH * STRB_W);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DONE} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;

  function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
    return (a >= BASE) && ({1'b0, a - BASE} < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return IDX_W'(off >> OFF_W);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  rd_state_e         rd_state_q, rd_state_d;
  logic [3:0]        rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic [1:0]        r_resp_q, r_resp_d;

  wr_state_e         wr_state_q, wr_state_d;
  logic [3:0]        wr_cnt_q, wr_cnt_d;
  logic              aw_got_q, aw_got_d;
  logic              w_got_q, w_got_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [STRB_W-1:0] wr_strb_q, wr_strb_d;
  logic [1:0]        b_resp_q, b_resp_d;

  logic              rd_hit_s, wr_hit_s, wr_commit_s, aw_hs_s, w_hs_s;
  logic [IDX_W-1:0]  rd_idx_s, wr_idx_s;

  assign rd_hit_s = addr_hit(rd_addr_q);
  assign rd_idx_s = addr_idx(rd_addr_q);
  assign wr_hit_s = addr_hit(wr_addr_q);
  assign wr_idx_s = addr_idx(wr_addr_q);

  // Readies are decoded from state but masked while reset is held.
  assign ar_ready = (rd_state_q == R_IDLE) && !rst_i;
  assign aw_ready = (wr_state_q == W_IDLE) && !aw_got_q && !rst_i;
  assign w_ready  = (wr_state_q == W_IDLE) && !w_got_q && !rst_i;
  assign aw_hs_s  = aw_valid && aw_ready;
  assign w_hs_s   = w_valid && w_ready;

  assign r_valid = (rd_state_q == R_DONE);
  assign r_data  = r_data_q;
  assign r_resp  = r_resp_q;
  assign b_valid = (wr_state_q == W_RESP);
  assign b_resp  = b_resp_q;

  // Read channel next-state: accept address, count latency, sample array, hold until taken.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_addr_d  = rd_addr_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_valid) begin
          rd_addr_d  = ar_addr;
          rd_cnt_d   = 4'(R_LAT);
          rd_state_d = R_WAIT;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_WAIT: begin
        if (rd_cnt_q == 4'd0) begin
          r_data_d   = rd_hit_s ? mem_q[rd_idx_s] : {DATA_W{1'b0}};
          r_resp_d   = rd_hit_s ? 2'b00 : 2'b11;
          rd_state_d = R_DONE;
        end else begin
          rd_cnt_d = rd_cnt_q - 4'd1;
        end
      end
      R_DONE: begin
        if (r_ready) begin
          rd_state_d = R_IDLE;
        end else begin
          rd_state_d = R_DONE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write channel next-state: collect AW and W in any order, count latency, commit, respond.
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_cnt_d    = wr_cnt_q;
    aw_got_d    = aw_got_q;
    w_got_d     = w_got_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_strb_d   = wr_strb_q;
    b_resp_d    = b_resp_q;
    wr_commit_s = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          wr_addr_d = aw_addr;
          aw_got_d  = 1'b1;
        end else begin
          aw_got_d  = aw_got_q;
        end
        if (w_hs_s) begin
          wr_data_d = w_data;
          wr_strb_d = w_strb;
          w_got_d   = 1'b1;
        end else begin
          w_got_d   = w_got_q;
        end
        if ((aw_got_q || aw_hs_s) && (w_got_q || w_hs_s)) begin
          wr_cnt_d   = 4'(W_LAT);
          wr_state_d = W_WAIT;
        end else begin
          wr_state_d = W_IDLE;
        end
      end
      W_WAIT: begin
        if (wr_cnt_q == 4'd0) begin
          wr_commit_s = 1'b1;
          b_resp_d    = wr_hit_s ? 2'b00 : 2'b11;
          aw_got_d    = 1'b0;
          w_got_d     = 1'b0;
          wr_state_d  = W_RESP;
        end else begin
          wr_cnt_d = wr_cnt_q - 4'd1;
        end
      end
      W_RESP: begin
        if (b_ready) begin
          wr_state_d = W_IDLE;
        end else begin
          wr_state_d = W_RESP;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Control and response registers for both channels.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= 4'd0;
      rd_addr_q  <= {ADDR_W{1'b0}};
      r_data_q   <= {DATA_W{1'b0}};
      r_resp_q   <= 2'b00;
      wr_state_q <= W_IDLE;
      wr_cnt_q   <= 4'd0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      wr_addr_q  <= {ADDR_W{1'b0}};
      wr_data_q  <= {DATA_W{1'b0}};
      wr_strb_q  <= {STRB_W{1'b0}};
      b_resp_q   <= 2'b00;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_addr_q  <= rd_addr_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      b_resp_q   <= b_resp_d;
    end
  end

  // Array byte-masked write port; a read sampling the same edge sees the old word.
  always_ff @(posedge clk_i) begin
    if (wr_commit_s && wr_hit_s) begin
      for (int i = 0; i < int'(STRB_W); i++) begin
        if (wr_strb_q[i]) begin
          mem_q[wr_idx_s][8*i +: 8] <= wr_data_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_slv.sv
// Directed plus randomized bench for axi_lite_mem_slv with an address-map/byte-lane reference model.
module tb_axi_lite_mem_slv;

  localparam int          R_LAT = 2;
  localparam int          W_LAT = 2;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] LIMIT = 32'h8000_1000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [31:0] ar_addr, r_data;
  logic [1:0]  r_resp, b_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [int unsigned];

  axi_lite_mem_slv #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(1024), .BASE(BASE), .R_LAT(R_LAT), .W_LAT(W_LAT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    return (a >= BASE) && (a < LIMIT);
  endfunction

  function automatic logic [1:0] m_resp(input logic [31:0] a);
    return m_hit(a) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int unsigned idx;
    if (!m_hit(a)) return 32'h0;
    idx = (a - BASE) / 4;
    return mdl.exists(idx) ? mdl[idx] : 32'hxxxx_xxxx;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned idx;
    logic [31:0] cur;
    if (m_hit(a)) begin
      idx = (a - BASE) / 4;
      cur = mdl.exists(idx) ? mdl[idx] : 32'hxxxx_xxxx;
      for (int b = 0; b < 4; b++) begin
        if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
      end
      mdl[idx] = cur;
    end
  endtask

  // Read with optional r_ready hold-off; checks latency, data, response and stability.
  task automatic do_read(input string tag, input logic [31:0] a, input int hold, output logic [31:0] d);
    int cyc;
    logic [1:0] rs;
    ar_addr = a;
    ar_valid = 1'b1;
    cyc = 0;
    while (!ar_ready && cyc < 50) begin step(); cyc++; end
    check({tag, "_ar_ready"}, 32'(ar_ready), 32'd1);
    step();
    ar_valid = 1'b0;
    cyc = 1;
    while (!r_valid && cyc < 50) begin step(); cyc++; end
    check({tag, "_r_lat"}, 32'(cyc), 32'(R_LAT + 2));
    d  = r_data;
    rs = r_resp;
    check({tag, "_r_data"}, d, m_read(a));
    check({tag, "_r_resp"}, 32'(rs), 32'(m_resp(a)));
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_ctl"}, {28'd0, r_valid, ar_ready, r_resp}, {28'd0, 1'b1, 1'b0, rs});
      check({tag, "_hold_data"}, r_data, d);
    end
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    check({tag, "_after_r"}, {30'd0, r_valid, ar_ready}, 32'd1);
  endtask

  // Write with channel ordering: 0 same cycle, 1 W first, 2 AW first (gap cycles apart).
  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int order, input int gap);
    int cyc;
    aw_addr = a;
    w_data  = d;
    w_strb  = s;
    if (order == 0) begin
      check({tag, "_rdy"}, {30'd0, aw_ready, w_ready}, 32'd3);
      aw_valid = 1'b1;
      w_valid  = 1'b1;
      step();
      aw_valid = 1'b0;
      w_valid  = 1'b0;
    end else begin
      if (order == 1) w_valid = 1'b1; else aw_valid = 1'b1;
      check({tag, "_rdy1"}, {30'd0, aw_ready, w_ready}, 32'd3);
      step();
      aw_valid = 1'b0;
      w_valid  = 1'b0;
      check({tag, "_rdy_got"}, {30'd0, aw_ready, w_ready}, (order == 1) ? 32'd2 : 32'd1);
      repeat (gap - 1) step();
      if (order == 1) aw_valid = 1'b1; else w_valid = 1'b1;
      step();
      aw_valid = 1'b0;
      w_valid  = 1'b0;
    end
    cyc = 1;
    while (!b_valid && cyc < 50) begin step(); cyc++; end
    check({tag, "_b_lat"}, 32'(cyc), 32'(W_LAT + 2));
    check({tag, "_b_resp"}, 32'(b_resp), 32'(m_resp(a)));
    m_write(a, d, s);
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    check({tag, "_after_b"}, {29'd0, b_valid, aw_ready, w_ready}, 32'd3);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int cyc;
    bit seen_b;
    ar_valid = 1'b0; ar_addr = 32'h0; r_ready = 1'b0;
    aw_valid = 1'b0; aw_addr = 32'h0; w_valid = 1'b0; w_data = 32'h0; w_strb = 4'h0; b_ready = 1'b0;

    // Reset state
    #2 rst_i = 1'b1;
    #2;
    check("rst_valids", {30'd0, r_valid, b_valid}, 32'd0);
    check("rst_readies", {29'd0, ar_ready, aw_ready, w_ready}, 32'd0);
    check("rst_r_data", r_data, 32'd0);
    check("rst_resps", {28'd0, r_resp, b_resp}, 32'd0);
    step(); step();
    rst_i = 1'b0;
    step();
    check("post_rst_readies", {29'd0, ar_ready, aw_ready, w_ready}, 32'd7);

    // Preload words used later so reads are never of uninitialized storage
    do_write("pre0", BASE, 32'h0BAD_F00D, 4'hF, 0, 0);
    do_write("pre20", BASE + 32'h20, 32'h0000_000A, 4'hF, 0, 0);
    do_write("pre30", BASE + 32'h30, 32'h3030_3030, 4'hF, 0, 0);
    for (int i = 0; i < 8; i++) do_write("pre_rand", BASE + 32'h100 + 32'(4 * i), $urandom, 4'hF, i % 3, 1 + (i % 3));

    // Write then read
    do_write("wr_basic", BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_read("rd_basic", BASE + 32'h10, 0, rd);
    check("rd_basic_const", rd, 32'hDEAD_BEEF);

    // Byte strobes, W three cycles ahead of AW
    do_write("wr_strb", BASE + 32'h10, 32'h1122_3344, 4'b0101, 1, 3);
    do_read("rd_strb", BASE + 32'h10, 0, rd);
    check("rd_strb_const", rd, 32'hDE22_BE44);

    // Decode errors
    do_read("rd_decerr", 32'h7FFF_FFFC, 0, rd);
    do_write("wr_decerr", 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, 0);
    do_read("rd_word0", BASE, 0, rd);
    check("rd_word0_const", rd, 32'h0BAD_F00D);

    // Backpressure on R
    do_read("rd_bp", BASE + 32'h10, 10, rd);

    // Collision: read sample and write commit on the same edge
    ar_addr = BASE + 32'h20; aw_addr = BASE + 32'h20; w_data = 32'h0000_000B; w_strb = 4'hF;
    ar_valid = 1'b1; aw_valid = 1'b1; w_valid = 1'b1;
    step();
    ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
    cyc = 1;
    while (!r_valid && cyc < 50) begin step(); cyc++; end
    check("coll_lat", 32'(cyc), 32'(R_LAT + 2));
    check("coll_b_same", 32'(b_valid), 32'd1);
    check("coll_old", r_data, 32'h0000_000A);
    r_ready = 1'b1; b_ready = 1'b1;
    step();
    r_ready = 1'b0; b_ready = 1'b0;
    m_write(BASE + 32'h20, 32'h0000_000B, 4'hF);
    do_read("coll_new", BASE + 32'h20, 0, rd);
    check("coll_new_const", rd, 32'h0000_000B);

    // Reset while a write is in its latency window
    aw_addr = BASE + 32'h30; w_data = 32'h5555_AAAA; w_strb = 4'hF;
    aw_valid = 1'b1; w_valid = 1'b1;
    step();
    aw_valid = 1'b0; w_valid = 1'b0;
    step();
    rst_i = 1'b1;
    #1;
    check("mid_rst_out", {28'd0, b_valid, ar_ready, aw_ready, w_ready}, 32'd0);
    step(); step();
    rst_i = 1'b0;
    step();
    check("mid_rst_release", {29'd0, ar_ready, aw_ready, w_ready}, 32'd7);
    seen_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (b_valid) seen_b = 1'b1;
    end
    check("mid_rst_no_b", 32'(seen_b), 32'd0);
    do_read("mid_rst_word", BASE + 32'h30, 0, rd);
    check("mid_rst_word_const", rd, 32'h3030_3030);

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: a = 32'h7FFF_FFFC;
          1: a = 32'h8000_1000;
          2: a = 32'h0000_0100;
          default: a = 32'hFFFF_FFFC;
        endcase
      end else begin
        a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 0) begin
        do_write("rnd_wr", a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(1, 3));
      end else begin
        do_read("rnd_rd", a, $urandom_range(0, 3), rd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
